// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator command outputs and the door sequencer.
package elevator_pkg;

    localparam logic [1:0] CAB_DOWN   = 2'b00;
    localparam logic [1:0] CAB_UP     = 2'b01;
    localparam logic [1:0] DOOR_CLOSE = 2'b10;
    localparam logic [1:0] DOOR_OPEN  = 2'b11;

    typedef enum logic [1:0] {
        SPD_STOP = 2'b00,
        SPD_SLOW = 2'b01,
        SPD_MED  = 2'b10,
        SPD_FAST = 2'b11
    } spd_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_OPENING,
        D_HOLD,
        D_EXPIRED,
        D_CLOSING
    } dstate_t;

endpackage

// File: rtl/elevator_actuator_if.sv
// Command bus from the elevator FSM plus the motor/buzzer pins it drives.
interface elevator_actuator_if;
    logic M, D, P, W, S;
    logic M0_UP, M0_DN, M1_OPN, M1_CLS, BUZ, R;

    modport master (
        output M, D, P, W, S,
        input  M0_UP, M0_DN, M1_OPN, M1_CLS, BUZ, R
    );

    modport slave (
        input  M, D, P, W, S,
        output M0_UP, M0_DN, M1_OPN, M1_CLS, BUZ, R
    );
endinterface

// File: rtl/elevator_pwm_gen.sv
// Free-running PWM counter with two independent duty comparators (cabin and door level).
module elevator_pwm_gen
    import elevator_pkg::*;
#(
    parameter int PWM_PERIOD = 100
) (
    input  logic Clk,
    input  logic Reset,
    input  spd_t lvl_a,
    input  spd_t lvl_b,
    output logic on_a,
    output logic on_b
);
    localparam int PCNT_W = $clog2(PWM_PERIOD - 1) + 1;
    localparam int Q      = PWM_PERIOD / 4;

    logic [PCNT_W-1:0] pcnt;

    function automatic logic [PCNT_W-1:0] thr(input spd_t lvl);
        return PCNT_W'(Q * int'(lvl));
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset)
            pcnt <= '0;
        else if (pcnt == PCNT_W'(PWM_PERIOD - 1))
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    assign on_a = (pcnt < thr(lvl_a));
    assign on_b = (pcnt < thr(lvl_b));
endmodule

// File: rtl/elevator_actuator.sv
// Field-side actuator: turns M/D/P/W/S commands into cabin/door PWM, door sequencing and buzzer.
module elevator_actuator
    import elevator_pkg::*;
#(
    parameter int PWM_PERIOD       = 100,
    parameter int DOOR_MOVE_CYCLES = 5000,
    parameter int DOOR_HOLD_CYCLES = 20000,
    parameter int BUZZ_CYCLES      = 1000
) (
    input  logic Clk,
    input  logic Reset,
    elevator_actuator_if.slave bus
);
    localparam int DMAX   = (DOOR_MOVE_CYCLES > DOOR_HOLD_CYCLES) ? DOOR_MOVE_CYCLES : DOOR_HOLD_CYCLES;
    localparam int DCNT_W = $clog2(DMAX - 1) + 1;
    localparam int BCNT_W = $clog2(BUZZ_CYCLES) + 1;
    localparam logic [DCNT_W-1:0] MOVE_LAST = DCNT_W'(DOOR_MOVE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] HOLD_LAST = DCNT_W'(DOOR_HOLD_CYCLES - 1);

    logic [1:0]        md;
    spd_t              pw;
    logic              cmd_vld, open_cmd, close_cmd;
    dstate_t           dstate;
    logic [DCNT_W-1:0] dcnt;
    spd_t              dlvl;
    logic [BCNT_W-1:0] bcnt;
    logic              cab_up_p0, cab_dn_p0;
    spd_t              cpw_p0;
    logic              cab_on, door_on;

    assign md        = {bus.M, bus.D};
    assign pw        = spd_t'({bus.P, bus.W});
    assign cmd_vld   = (pw != SPD_STOP);
    assign open_cmd  = cmd_vld && (md == DOOR_OPEN);
    assign close_cmd = cmd_vld && (md == DOOR_CLOSE);

    elevator_pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .Clk   (Clk),
        .Reset (Reset),
        .lvl_a (cpw_p0),
        .lvl_b (dlvl),
        .on_a  (cab_on),
        .on_b  (door_on)
    );

    // Door sequencer; door pins and R follow the state one clock later
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            dstate     <= D_IDLE;
            dcnt       <= '0;
            dlvl       <= SPD_STOP;
            bus.M1_OPN <= 1'b0;
            bus.M1_CLS <= 1'b0;
            bus.R      <= 1'b0;
        end else begin
            bus.M1_OPN <= (dstate == D_OPENING) && door_on;
            bus.M1_CLS <= (dstate == D_CLOSING) && door_on;
            bus.R      <= (dstate == D_EXPIRED);
            unique case (dstate)
                D_IDLE: begin
                    if (open_cmd) begin
                        dstate <= D_OPENING;
                        dcnt   <= '0;
                        dlvl   <= pw;
                    end
                end
                D_OPENING, D_HOLD, D_EXPIRED: begin
                    if (close_cmd) begin
                        dstate <= D_CLOSING;
                        dcnt   <= '0;
                        dlvl   <= pw;
                    end else if (dstate == D_OPENING) begin
                        if (dcnt == MOVE_LAST) begin
                            dstate <= D_HOLD;
                            dcnt   <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end else if (dstate == D_HOLD) begin
                        if (dcnt == HOLD_LAST) begin
                            dstate <= D_EXPIRED;
                            dcnt   <= '0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                D_CLOSING: begin
                    // A reopen restarts the full open stroke from the current door position
                    if (open_cmd) begin
                        dstate <= D_OPENING;
                        dcnt   <= '0;
                        dlvl   <= pw;
                    end else if (dcnt == MOVE_LAST) begin
                        dstate <= D_IDLE;
                        dcnt   <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: begin
                    dstate <= D_IDLE;
                    dcnt   <= '0;
                end
            endcase
        end
    end

    // Stage p0: cabin command capture and buzzer stretch; stage p1: cabin/buzzer pins
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cab_up_p0 <= 1'b0;
            cab_dn_p0 <= 1'b0;
            cpw_p0    <= SPD_STOP;
            bcnt      <= '0;
            bus.M0_UP <= 1'b0;
            bus.M0_DN <= 1'b0;
            bus.BUZ   <= 1'b0;
        end else begin
            cab_up_p0 <= cmd_vld && (md == CAB_UP);
            cab_dn_p0 <= cmd_vld && (md == CAB_DOWN);
            cpw_p0    <= pw;
            if (bus.S)
                bcnt <= BCNT_W'(BUZZ_CYCLES);
            else if (bcnt != '0)
                bcnt <= bcnt - 1'b1;
            // Cabin is interlocked against any door activity
            bus.M0_UP <= cab_up_p0 && cab_on && (dstate == D_IDLE);
            bus.M0_DN <= cab_dn_p0 && cab_on && (dstate == D_IDLE);
            bus.BUZ   <= (bcnt != '0);
        end
    end
endmodule

// File: tb/tb_elevator_actuator.sv
// Directed bench for elevator_actuator with a cycle-level reference model feeding a scoreboard.
module tb_elevator_actuator;

    localparam int PWM_PERIOD       = 8;
    localparam int DOOR_MOVE_CYCLES = 4;
    localparam int DOOR_HOLD_CYCLES = 6;
    localparam int BUZZ_CYCLES      = 3;

    // {M, D, P, W, S}
    localparam logic [4:0] IDLE_C      = 5'b00000;
    localparam logic [4:0] CAB_UP_FAST = 5'b01110;
    localparam logic [4:0] CAB_DN_MED  = 5'b00100;
    localparam logic [4:0] OPEN_SLOW   = 5'b11010;
    localparam logic [4:0] CLOSE_SLOW  = 5'b10010;
    localparam logic [4:0] OPEN_FAST   = 5'b11110;
    localparam logic [4:0] CLOSE_FAST  = 5'b10110;
    localparam logic [4:0] CHIME       = 5'b00001;

    logic Clk;
    logic Reset;
    elevator_actuator_if bus();

    elevator_actuator #(
        .PWM_PERIOD       (PWM_PERIOD),
        .DOOR_MOVE_CYCLES (DOOR_MOVE_CYCLES),
        .DOOR_HOLD_CYCLES (DOOR_HOLD_CYCLES),
        .BUZZ_CYCLES      (BUZZ_CYCLES)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_up, n_dn, n_opn, n_cls, n_buz, n_r;
    logic [5:0] last_got;

    // Reference model: phase 0 idle, 1 opening, 2 hold, 3 expired, 4 closing
    int m_phase, m_rem, m_lvl, m_cpw, m_buz, m_pc;
    bit m_cup, m_cdn;
    logic [5:0] exp_q[$];

    task automatic model_tick(input logic rn, input logic [4:0] c);
        logic [5:0] e;
        bit mm, dd, ss;
        int pw;
        mm = c[4];
        dd = c[3];
        pw = int'(c[2:1]);
        ss = c[0];
        e  = '0;
        if (!rn) begin
            m_phase = 0; m_rem = 0; m_lvl = 0; m_cpw = 0; m_buz = 0; m_pc = 0;
            m_cup = 0; m_cdn = 0;
        end else begin
            e[5] = m_cup && (m_pc < (PWM_PERIOD / 4) * m_cpw) && (m_phase == 0);
            e[4] = m_cdn && (m_pc < (PWM_PERIOD / 4) * m_cpw) && (m_phase == 0);
            e[3] = (m_phase == 1) && (m_pc < (PWM_PERIOD / 4) * m_lvl);
            e[2] = (m_phase == 4) && (m_pc < (PWM_PERIOD / 4) * m_lvl);
            e[1] = (m_buz > 0);
            e[0] = (m_phase == 3);
            m_cup = !mm && dd && (pw != 0);
            m_cdn = !mm && !dd && (pw != 0);
            m_cpw = pw;
            if (pw != 0 && mm && dd && (m_phase == 0 || m_phase == 4)) begin
                m_phase = 1; m_rem = DOOR_MOVE_CYCLES; m_lvl = pw;
            end else if (pw != 0 && mm && !dd && (m_phase >= 1 && m_phase <= 3)) begin
                m_phase = 4; m_rem = DOOR_MOVE_CYCLES; m_lvl = pw;
            end else if (m_phase == 1 || m_phase == 2 || m_phase == 4) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_phase == 1) begin m_phase = 2; m_rem = DOOR_HOLD_CYCLES; end
                    else if (m_phase == 2) m_phase = 3;
                    else m_phase = 0;
                end
            end
            if (ss) m_buz = BUZZ_CYCLES;
            else if (m_buz > 0) m_buz--;
            m_pc = (m_pc + 1) % PWM_PERIOD;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_up = 0; n_dn = 0; n_opn = 0; n_cls = 0; n_buz = 0; n_r = 0;
    endtask

    task automatic step(input logic rn, input logic [4:0] c);
        logic [5:0] got, exp;
        Reset = rn;
        {bus.M, bus.D, bus.P, bus.W, bus.S} = c;
        model_tick(rn, c);
        @(posedge Clk);
        #1;
        cyc++;
        got = {bus.M0_UP, bus.M0_DN, bus.M1_OPN, bus.M1_CLS, bus.BUZ, bus.R};
        last_got = got;
        n_up  += int'(bus.M0_UP);
        n_dn  += int'(bus.M0_DN);
        n_opn += int'(bus.M1_OPN);
        n_cls += int'(bus.M1_CLS);
        n_buz += int'(bus.BUZ);
        n_r   += int'(bus.R);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty cyc=%0d got=%b", cyc, got);
        end else begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("FAIL outs cyc=%0d got(up,dn,opn,cls,buz,r)=%b exp=%b", cyc, got, exp);
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        clr();
        Reset = 1'b0;
        {bus.M, bus.D, bus.P, bus.W, bus.S} = IDLE_C;

        // Reset, then cabin up at 75 %
        repeat (2) step(1'b0, CAB_UP_FAST);
        check("reset_outs", int'(last_got), 0);
        clr();
        repeat (8) step(1'b1, CAB_UP_FAST);
        clr();
        repeat (8) step(1'b1, CAB_UP_FAST);
        check("up_duty", n_up, 6);
        check("dn_quiet", n_dn, 0);

        // Open stroke at 25 %, cabin down requested during hold
        step(1'b1, OPEN_SLOW);
        clr();
        repeat (4) step(1'b1, IDLE_C);
        check("open_slow_pwm", n_opn, 1);
        clr();
        repeat (5) step(1'b1, CAB_DN_MED);
        step(1'b1, IDLE_C);
        check("interlock_dn", n_dn, 0);
        check("hold_no_r", n_r, 0);
        check("hold_no_opn", n_opn, 0);
        clr();
        repeat (4) step(1'b1, IDLE_C);
        check("r_held", n_r, 4);

        // Close while expired
        step(1'b1, CLOSE_SLOW);
        clr();
        step(1'b1, IDLE_C);
        check("r_drop", int'(last_got[0]), 0);
        repeat (3) step(1'b1, IDLE_C);
        check("close_slow_pwm", n_cls, 2);
        clr();
        repeat (9) step(1'b1, CAB_UP_FAST);
        check("cab_after_close", n_up, 6);
        check("cab_after_close_r", n_r, 0);

        // Reopen on the second clock of closing
        step(1'b1, OPEN_FAST);
        step(1'b1, CLOSE_FAST);
        step(1'b1, IDLE_C);
        step(1'b1, OPEN_FAST);
        clr();
        repeat (10) step(1'b1, IDLE_C);
        check("reopen_cls_off", n_cls, 0);
        check("reopen_full_stroke", n_opn, 4);
        check("reopen_no_r", n_r, 0);
        step(1'b1, IDLE_C);
        check("reopen_r", int'(last_got[0]), 1);
        step(1'b1, CLOSE_FAST);
        repeat (5) step(1'b1, IDLE_C);

        // Buzzer single and extended pulse
        clr();
        step(1'b1, CHIME);
        repeat (6) step(1'b1, IDLE_C);
        check("buz_single", n_buz, 3);
        clr();
        step(1'b1, CHIME);
        step(1'b1, IDLE_C);
        step(1'b1, CHIME);
        repeat (6) step(1'b1, IDLE_C);
        check("buz_extend", n_buz, 5);

        // Reset in the middle of an open stroke
        step(1'b1, OPEN_FAST);
        repeat (2) step(1'b1, IDLE_C);
        step(1'b0, IDLE_C);
        check("midreset_outs", int'(last_got), 0);
        clr();
        repeat (9) step(1'b1, CAB_UP_FAST);
        check("midreset_idle_cab", n_up, 6);
        check("midreset_no_opn", n_opn, 0);
        clr();
        repeat (12) step(1'b1, CAB_UP_FAST);
        check("midreset_no_r", n_r, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
